// File: rtl/cpc_clk_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpc_clk_sequencer_if : PLL control and per-domain reset bundle.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cpc_clk_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   pll_locked;
  logic                   relock_req;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic                   ready;
  logic                   lock_lost;
  logic                   fault;
  logic [2:0]             retry_count;
`ifdef CPC_CLKSEQ_LOCKCNT_EN
  logic [7:0]             lock_loss_count;
`endif

  modport master (
    input  pll_locked,
    input  relock_req,
    output pll_rst,
    output domain_rst_n,
    output ready,
    output lock_lost,
    output fault,
    output retry_count
`ifdef CPC_CLKSEQ_LOCKCNT_EN
    , output lock_loss_count
`endif
  );

  modport slave (
    output pll_locked,
    output relock_req,
    input  pll_rst,
    input  domain_rst_n,
    input  ready,
    input  lock_lost,
    input  fault,
    input  retry_count
`ifdef CPC_CLKSEQ_LOCKCNT_EN
    , input lock_loss_count
`endif
  );
endinterface
`default_nettype wire

// File: rtl/cpc_clk_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpc_clk_sequencer : PLL reset/lock qualification and staggered domain    |
// | reset release. Optional lock-loss counter: CPC_CLKSEQ_LOCKCNT_EN. Rev 1.0|
// +--------------------------------------------------------------------------+
module cpc_clk_sequencer #(
  parameter int RST_HOLD_CYCLES     = 500,
  parameter int LOCK_STABLE_CYCLES  = 50000,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int NUM_DOMAINS         = 4,
  parameter int STAGGER_CYCLES      = 16,
  parameter int MAX_RETRIES         = 7
) (
  input wire                  refclk,
  input wire                  rst_n,
  cpc_clk_sequencer_if.master bus
);

  localparam int REL_CYCLES = NUM_DOMAINS * STAGGER_CYCLES;
  localparam int MAX_AB     = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CD     = (LOCK_TIMEOUT_CYCLES > REL_CYCLES) ? LOCK_TIMEOUT_CYCLES : REL_CYCLES;
  localparam int MAX_ALL    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W      = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] LOAD_RST     = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_REL     = CNT_W'(REL_CYCLES);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sync1_q, lock_sync_q;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   fault_q, fault_d;
  logic [2:0]             retry_q, retry_d;
  logic [2:0]             retry_inc;
  logic                   enter;
  logic [NUM_DOMAINS-1:0] rel_mask;

  // The release counter runs from REL_CYCLES down to 0; bit i is due once
  // STAGGER*(i+1) cycles have elapsed since RELEASE was entered.
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_rel_mask
    assign rel_mask[i] = (cnt_q <= CNT_W'(REL_CYCLES + 1 - STAGGER_CYCLES * (i + 1)));
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      sync1_q     <= bus.pll_locked;
      lock_sync_q <= sync1_q;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= LOAD_RST;
      pll_rst_q   <= 1'b1;
      dom_q       <= '0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      fault_q     <= 1'b0;
      retry_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      dom_q       <= dom_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      fault_q     <= fault_d;
      retry_q     <= retry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    enter       = 1'b0;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    retry_inc   = retry_q + 3'd1;
    case (state_q)
      S_RESET_PLL: begin
        if (bus.relock_req) begin
          enter = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_WAIT_LOCK;
          enter   = 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          enter   = 1'b1;
        end else if (lock_sync_q) begin
          state_d = S_STABLE;
          enter   = 1'b1;
        end else if (cnt_q == '0) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
          enter   = 1'b1;
        end
      end
      S_STABLE: begin
        // A lock glitch restarts the wait with a fresh timeout, not a retry.
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          enter   = 1'b1;
        end else if (!lock_sync_q) begin
          state_d = S_WAIT_LOCK;
          enter   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_RELEASE;
          enter   = 1'b1;
        end
      end
      S_RELEASE, S_RUN: begin
        if (!lock_sync_q) begin
          lock_lost_d = 1'b1;
          state_d     = S_RESET_PLL;
          enter       = 1'b1;
        end else if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          enter   = 1'b1;
        end else if (state_q == S_RELEASE && cnt_q == '0) begin
          state_d = S_RUN;
          enter   = 1'b1;
          retry_d = 3'd0;
        end
      end
      S_FAULT: begin
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          enter   = 1'b1;
          retry_d = 3'd0;
        end
      end
      default: begin
        state_d = S_RESET_PLL;
        enter   = 1'b1;
      end
    endcase

    if (enter) begin
      case (state_d)
        S_RESET_PLL: cnt_d = LOAD_RST;
        S_WAIT_LOCK: cnt_d = LOAD_TIMEOUT;
        S_STABLE:    cnt_d = LOAD_STABLE;
        S_RELEASE:   cnt_d = LOAD_REL;
        default:     cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
    if (state_d == S_RUN) begin
      dom_d = '1;
    end else if (state_d == S_RELEASE && !enter) begin
      dom_d = rel_mask;
    end else begin
      dom_d = '0;
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.domain_rst_n = dom_q;
  assign bus.ready        = ready_q;
  assign bus.lock_lost    = lock_lost_q;
  assign bus.fault        = fault_q;
  assign bus.retry_count  = retry_q;

`ifdef CPC_CLKSEQ_LOCKCNT_EN
  logic [7:0] llc_q;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      llc_q <= 8'd0;
    end else if (lock_lost_d && llc_q != 8'hFF) begin
      llc_q <= llc_q + 8'd1;
    end
  end

  assign bus.lock_loss_count = llc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpc_clk_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpc_clk_sequencer : directed bench with hand-derived cycle timings.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cpc_clk_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  cpc_clk_sequencer_if #(.NUM_DOMAINS(4)) bus ();

  cpc_clk_sequencer #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .NUM_DOMAINS        (4),
    .STAGGER_CYCLES     (2),
    .MAX_RETRIES        (3)
  ) dut (
    .refclk(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Cycle n is the interval just before refclk edge n; land 1 time unit into it.
  task automatic goto_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  function automatic logic [3:0] dom_exp(input int c, input int base);
    if (c >= base + 6)      return 4'b1111;
    else if (c >= base + 4) return 4'b0111;
    else if (c >= base + 2) return 4'b0011;
    else if (c >= base)     return 4'b0001;
    else                    return 4'b0000;
  endfunction

  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    rst_n          = 1'b0;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_pll_rst",   32'(bus.pll_rst), 32'd1);
    chk("rst_domain",    32'(bus.domain_rst_n), 32'h0);
    chk("rst_ready",     32'(bus.ready), 32'd0);
    chk("rst_lock_lost", 32'(bus.lock_lost), 32'd0);
    chk("rst_fault",     32'(bus.fault), 32'd0);
    chk("rst_retry",     32'(bus.retry_count), 32'd0);

    // Bring-up: lock from cycle 10, first domain release visible at 23.
    for (int c = 0; c <= 30; c++) begin
      goto_cyc(c);
      if (c == 10) bus.pll_locked = 1'b1;
      chk("up_pll_rst", 32'(bus.pll_rst), 32'(c <= 3));
      chk("up_domain",  32'(bus.domain_rst_n), 32'(dom_exp(c, 23)));
      chk("up_ready",   32'(bus.ready), 32'(c >= 30));
    end
    chk("up_retry", 32'(bus.retry_count), 32'd0);

    // relock_req in RUN, then a 3-cycle lock glitch while in STABLE.
    goto_cyc(31);
    bus.relock_req = 1'b1;
    goto_cyc(32);
    bus.relock_req = 1'b0;
`ifdef CPC_CLKSEQ_LOCKCNT_EN
    chk("relock_llc", 32'(bus.lock_loss_count), 32'd0);
`endif
    for (int c = 32; c <= 61; c++) begin
      goto_cyc(c);
      if (c == 38) bus.pll_locked = 1'b0;
      if (c == 41) bus.pll_locked = 1'b1;
      chk("gl_pll_rst",   32'(bus.pll_rst), 32'(c <= 35));
      chk("gl_domain",    32'(bus.domain_rst_n), 32'(dom_exp(c, 54)));
      chk("gl_ready",     32'(bus.ready), 32'(c >= 61));
      chk("gl_lock_lost", 32'(bus.lock_lost), 32'd0);
      chk("gl_retry",     32'(bus.retry_count), 32'd0);
    end

    // Lock loss in RUN: teardown visible at 65, full re-sequence after.
    for (int c = 62; c <= 87; c++) begin
      goto_cyc(c);
      if (c == 62) bus.pll_locked = 1'b0;
      if (c == 65) bus.pll_locked = 1'b1;
      chk("ll_lock_lost", 32'(bus.lock_lost), 32'(c == 65));
      chk("ll_pll_rst",   32'(bus.pll_rst), 32'(c >= 65 && c <= 68));
      chk("ll_ready",     32'(bus.ready), 32'(c <= 64 || c >= 87));
      chk("ll_domain",    32'(bus.domain_rst_n), 32'((c <= 64) ? 4'b1111 : dom_exp(c, 80)));
    end
`ifdef CPC_CLKSEQ_LOCKCNT_EN
    chk("ll_llc", 32'(bus.lock_loss_count), 32'd1);
`endif

    // rst_n asserted mid-RELEASE with domain_rst_n at 0011.
    goto_cyc(88);
    bus.relock_req = 1'b1;
    goto_cyc(89);
    bus.relock_req = 1'b0;
    goto_cyc(106);
    chk("mid_domain", 32'(bus.domain_rst_n), 32'h3);
    rst_n = 1'b0;
    goto_cyc(107);
    chk("mr_pll_rst",   32'(bus.pll_rst), 32'd1);
    chk("mr_domain",    32'(bus.domain_rst_n), 32'h0);
    chk("mr_ready",     32'(bus.ready), 32'd0);
    chk("mr_lock_lost", 32'(bus.lock_lost), 32'd0);
    chk("mr_fault",     32'(bus.fault), 32'd0);
    chk("mr_retry",     32'(bus.retry_count), 32'd0);
`ifdef CPC_CLKSEQ_LOCKCNT_EN
    chk("mr_llc", 32'(bus.lock_loss_count), 32'd0);
`endif
    rst_n          = 1'b1;
    bus.pll_locked = 1'b0;

    // Timeouts with lock held low: each attempt is 4 + 32 cycles.
    goto_cyc(142);
    chk("to1_retry_pre", 32'(bus.retry_count), 32'd0);
    chk("to1_pll_rst",   32'(bus.pll_rst), 32'd0);
    goto_cyc(143);
    chk("to1_retry",     32'(bus.retry_count), 32'd1);
    chk("to1_pll_rst_h", 32'(bus.pll_rst), 32'd1);
    chk("to1_fault",     32'(bus.fault), 32'd0);
    goto_cyc(178);
    chk("to2_retry_pre", 32'(bus.retry_count), 32'd1);
    goto_cyc(179);
    chk("to2_retry",     32'(bus.retry_count), 32'd2);
    goto_cyc(214);
    chk("to3_fault_pre", 32'(bus.fault), 32'd0);
    chk("to3_retry_pre", 32'(bus.retry_count), 32'd2);
    goto_cyc(215);
    chk("to3_fault",     32'(bus.fault), 32'd1);
    chk("to3_retry",     32'(bus.retry_count), 32'd3);
    chk("to3_pll_rst",   32'(bus.pll_rst), 32'd1);
    chk("to3_domain",    32'(bus.domain_rst_n), 32'h0);
    goto_cyc(216);
    chk("fault_hold", 32'(bus.fault), 32'd1);
    bus.relock_req = 1'b1;
    goto_cyc(217);
    bus.relock_req = 1'b0;
    for (int c = 217; c <= 221; c++) begin
      goto_cyc(c);
      chk("fr_pll_rst", 32'(bus.pll_rst), 32'(c <= 220));
      chk("fr_fault",   32'(bus.fault), 32'd0);
      chk("fr_retry",   32'(bus.retry_count), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
